timer_ctrl: RTL and testbench

Sequencer for the `timer_counter` datapath. It latches a run configuration on `start` and drives the counter's control inputs through a fixed sequence: a one-cycle init load, then prescaled count pulses. It detects the terminal count in one-shot or periodic, up or down modes and raises a sticky interrupt with acknowledge and overrun reporting. It sits between the register/bus interface and one counter instance.

---
 rtl/timer_ctrl.sv | 164 ++++++++++++++++
 tb/tb_timer_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// timer_ctrl: sequencer for one timer_counter datapath.
// Latches a run configuration on start, issues a one-cycle init load, then
// prescaled count pulses, detects the terminal count (one-shot / periodic,
// up / down) and raises a sticky interrupt with overrun reporting.
//
// Request protocol: start, stop and irq_ack are single-cycle level requests
// sampled on the rising clock edge; there is no ready back-pressure, a
// request is acted on (or, for a start with min > max, rejected with a
// cfg_err pulse) in the cycle it is sampled, and stop outranks start.
module timer_ctrl #(
    parameter int COUNTER_SIZE  = 8,
    parameter int PRESCALE_SIZE = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic [1:0]               mode,
    input  logic [PRESCALE_SIZE-1:0] prescale,
    input  logic [COUNTER_SIZE-1:0]  min,
    input  logic [COUNTER_SIZE-1:0]  max,
    input  logic [COUNTER_SIZE-1:0]  cnt_value,
    input  logic                     irq_ack,
    output logic                     cnt_pulse,
    output logic                     cnt_up,
    output logic                     cnt_down,
    output logic                     cnt_init,
    output logic                     cnt_free,
    output logic [COUNTER_SIZE-1:0]  cnt_init_val,
    output logic                     busy,
    output logic                     done,
    output logic                     irq,
    output logic                     irq_ovf,
    output logic                     cfg_err,
    output logic [1:0]               dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [PRESCALE_SIZE-1:0] pre_q, pre_d;
    logic [1:0]               mode_q, mode_d;
    logic [PRESCALE_SIZE-1:0] pcfg_q, pcfg_d;
    logic [COUNTER_SIZE-1:0]  min_q, min_d;
    logic [COUNTER_SIZE-1:0]  max_q, max_d;
    logic                     irq_q, irq_d;
    logic                     ovf_q, ovf_d;
    logic                     cfg_err_q, cfg_err_d;

    logic                     start_ok;
    logic                     start_bad;
    logic                     in_run;
    logic                     tick;
    logic                     at_term;
    logic                     term_evt;
    logic [COUNTER_SIZE-1:0]  term_val;

    // Request qualification and terminal-count detection from registered state.
    always_comb begin
        start_ok  = start && !stop && (min <= max);
        start_bad = start && !stop && (min > max);
        in_run    = (state_q == S_RUN);
        tick      = in_run && (pre_q == pcfg_q);
        term_val  = mode_q[1] ? min_q : max_q;
        at_term   = (cnt_value == term_val);
        term_evt  = tick && at_term;
    end

    // Next state, prescaler and configuration latch.
    always_comb begin
        state_d = state_q;
        pre_d   = '0;
        mode_d  = mode_q;
        pcfg_d  = pcfg_q;
        min_d   = min_q;
        max_d   = max_q;
        if (start_ok) begin
            mode_d = mode;
            pcfg_d = prescale;
            min_d  = min;
            max_d  = max;
        end
        case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (stop)          state_d = S_IDLE;
                else if (start_ok) state_d = S_LOAD;
                else               state_d = S_RUN;
            end
            S_RUN: begin
                pre_d = tick ? '0 : pre_q + PRESCALE_SIZE'(1);
                if (stop)                       state_d = S_IDLE;
                else if (start_ok)              state_d = S_LOAD;
                else if (term_evt && !mode_q[0]) state_d = S_DONE;
            end
            default: begin
                if (stop)          state_d = S_IDLE;
                else if (start_ok) state_d = S_LOAD;
            end
        endcase
    end

    // Sticky interrupt and overrun flag; a coincident ack only clears overrun.
    always_comb begin
        irq_d     = irq_q;
        ovf_d     = ovf_q;
        cfg_err_d = start_bad;
        if (term_evt) begin
            irq_d = 1'b1;
            if (irq_ack)    ovf_d = 1'b0;
            else if (irq_q) ovf_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
            ovf_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pre_q     <= '0;
            mode_q    <= '0;
            pcfg_q    <= '0;
            min_q     <= '0;
            max_q     <= '0;
            irq_q     <= 1'b0;
            ovf_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            mode_q    <= mode_d;
            pcfg_q    <= pcfg_d;
            min_q     <= min_d;
            max_q     <= max_d;
            irq_q     <= irq_d;
            ovf_q     <= ovf_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Counter controls decoded from registered state only.
    always_comb begin
        cnt_pulse    = tick && (!at_term || mode_q[0]);
        cnt_up       = in_run && !mode_q[1];
        cnt_down     = in_run && mode_q[1];
        cnt_init     = (state_q == S_LOAD);
        cnt_free     = 1'b0;
        cnt_init_val = mode_q[1] ? max_q : min_q;
        busy         = (state_q == S_LOAD) || (state_q == S_RUN);
        done         = (state_q == S_DONE);
        irq          = irq_q;
        irq_ovf      = ovf_q;
        cfg_err      = cfg_err_q;
        dbg_state    = state_q;
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: a behavioural timer_counter closes the loop, directed
// scenarios push expected events (relative cycle, kind, data) and a negedge
// monitor pops and compares each event the controller presents.
module tb_timer_ctrl;

    localparam int K_INIT  = 1;
    localparam int K_PULSE = 2;
    localparam int K_IRQ   = 3;
    localparam int K_OVF   = 4;
    localparam int K_CERR  = 5;
    localparam int K_DONE  = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       irq_ack = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] prescale = 8'd0;
    logic [7:0] cfg_min = 8'd0;
    logic [7:0] cfg_max = 8'd0;
    logic [7:0] cnt_value = 8'd0;
    logic       cnt_pulse, cnt_up, cnt_down, cnt_init, cnt_free;
    logic [7:0] cnt_init_val;
    logic       busy, done, irq, irq_ovf, cfg_err;
    logic [1:0] dbg_state;
    logic [9:0] outs;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          t0 = 0;
    logic [7:0]  mdl_min = 8'd0;
    logic [7:0]  mdl_max = 8'd0;
    logic        irq_p = 1'b0;
    logic        ovf_p = 1'b0;
    logic        done_p = 1'b0;

    timer_ctrl #(.COUNTER_SIZE(8), .PRESCALE_SIZE(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .prescale(prescale), .min(cfg_min), .max(cfg_max),
        .cnt_value(cnt_value), .irq_ack(irq_ack),
        .cnt_pulse(cnt_pulse), .cnt_up(cnt_up), .cnt_down(cnt_down),
        .cnt_init(cnt_init), .cnt_free(cnt_free), .cnt_init_val(cnt_init_val),
        .busy(busy), .done(done), .irq(irq), .irq_ovf(irq_ovf),
        .cfg_err(cfg_err), .dbg_state(dbg_state)
    );

    assign outs = {cnt_pulse, cnt_up, cnt_down, cnt_init, cnt_free,
                   busy, done, irq, irq_ovf, cfg_err};

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural timer_counter with wrap between the bounds.
    always @(posedge clk) begin
        if (rst)
            cnt_value <= 8'd0;
        else if (cnt_init)
            cnt_value <= cnt_init_val;
        else if (cnt_pulse) begin
            if (cnt_up)
                cnt_value <= (cnt_value == mdl_max) ? mdl_min : cnt_value + 8'd1;
            else if (cnt_down)
                cnt_value <= (cnt_value == mdl_min) ? mdl_max : cnt_value - 8'd1;
        end
    end

    function automatic void push(input int rel, input int kind, input int aux, input int data);
        exp_q.push_back({16'(rel), 4'(kind), 4'(aux), 8'(data)});
    endfunction

    task automatic mon_event(input int kind, input int aux, input int data);
        logic [31:0] obs;
        logic [31:0] exp_v;
        obs = {16'(cyc - t0), 4'(kind), 4'(aux), 8'(data)};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL event: got unexpected rel=%0d kind=%0d aux=%0h data=%0d, expected none",
                     obs[31:16], obs[15:12], obs[11:8], obs[7:0]);
        end else begin
            exp_v = exp_q.pop_front();
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL event: got rel=%0d kind=%0d aux=%0h data=%0d, expected rel=%0d kind=%0d aux=%0h data=%0d",
                         obs[31:16], obs[15:12], obs[11:8], obs[7:0],
                         exp_v[31:16], exp_v[15:12], exp_v[11:8], exp_v[7:0]);
            end
        end
    endtask

    // Monitor: report every event the controller presents, in kind order.
    always @(negedge clk) begin
        if (cnt_init)          mon_event(K_INIT, 0, int'(cnt_init_val));
        if (cnt_pulse)         mon_event(K_PULSE, int'({cnt_up, cnt_down}), int'(cnt_value));
        if (irq && !irq_p)     mon_event(K_IRQ, 0, 0);
        if (irq_ovf && !ovf_p) mon_event(K_OVF, 0, 0);
        if (cfg_err)           mon_event(K_CERR, 0, 0);
        if (done && !done_p)   mon_event(K_DONE, 0, 0);
        irq_p  <= irq;
        ovf_p  <= irq_ovf;
        done_p <= done;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rel(input int r);
        while (cyc < t0 + r) step();
    endtask

    task automatic do_start(input logic [1:0] m, input logic [7:0] p,
                            input logic [7:0] mn, input logic [7:0] mx, input bit new_run);
        mode     = m;
        prescale = p;
        cfg_min  = mn;
        cfg_max  = mx;
        start    = 1'b1;
        if (new_run) begin
            t0      = cyc;
            mdl_min = mn;
            mdl_max = mx;
        end
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic push_periodic_a();
        push(1, K_INIT, 0, 2);
        push(3, K_PULSE, 2, 2);
        push(5, K_PULSE, 2, 3);
        push(7, K_PULSE, 2, 4);
        push(9, K_PULSE, 2, 5);
        push(10, K_IRQ, 0, 0);
        push(11, K_PULSE, 2, 2);
    endtask

    initial begin
        // Reset
        repeat (3) step();
        chk("reset_outs", 32'(outs), 32'd0);
        chk("reset_init_val", 32'(cnt_init_val), 32'd0);
        chk("reset_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        step();

        // A: periodic up, min=2 max=5 P=1, overrun without ack
        push_periodic_a();
        push(13, K_PULSE, 2, 3);
        push(15, K_PULSE, 2, 4);
        push(17, K_PULSE, 2, 5);
        push(18, K_OVF, 0, 0);
        push(19, K_PULSE, 2, 2);
        do_start(2'b01, 8'd1, 8'd2, 8'd5, 1'b1);
        wait_rel(10);
        chk("a_irq_busy", 32'({irq, busy}), 32'b11);
        wait_rel(20);
        do_stop();
        chk("a_stop_busy", 32'(busy), 32'd0);
        chk("a_stop_state", 32'(dbg_state), 32'd0);
        chk("a_stop_value", 32'(cnt_value), 32'd3);
        wait_rel(22);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("a_ack_clear", 32'({irq, irq_ovf}), 32'b00);
        wait_rel(25);
        chk("a_frozen_value", 32'(cnt_value), 32'd3);

        // B: one-shot down, min=0 max=3 P=0, then a rejected start in DONE
        push(1, K_INIT, 0, 3);
        push(2, K_PULSE, 1, 3);
        push(3, K_PULSE, 1, 2);
        push(4, K_PULSE, 1, 1);
        push(6, K_IRQ, 0, 0);
        push(6, K_DONE, 0, 0);
        push(9, K_CERR, 0, 0);
        do_start(2'b10, 8'd0, 8'd0, 8'd3, 1'b1);
        wait_rel(8);
        chk("b_done", 32'({done, busy}), 32'b10);
        chk("b_hold_value", 32'(cnt_value), 32'd0);
        chk("b_no_dir", 32'({cnt_up, cnt_down, cnt_pulse}), 32'd0);
        do_start(2'b01, 8'd0, 8'd6, 8'd4, 1'b0);
        chk("b_reject_state", 32'(dbg_state), 32'd3);
        wait_rel(10);
        chk("b_cfg_err_len", 32'({cfg_err, done}), 32'b01);

        // C: start and stop together in RUN go to IDLE
        push(1, K_INIT, 0, 0);
        push(4, K_PULSE, 2, 0);
        push(7, K_PULSE, 2, 1);
        do_start(2'b01, 8'd2, 8'd0, 8'd7, 1'b1);
        wait_rel(8);
        start   = 1'b1;
        stop    = 1'b1;
        cfg_min = 8'd3;
        cfg_max = 8'd5;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("c_idle", 32'({dbg_state, busy, done}), 32'd0);
        wait_rel(12);
        chk("c_value", 32'(cnt_value), 32'd2);

        // D: terminal event coincident with ack while irq is pending
        push(1, K_INIT, 0, 0);
        push(3, K_PULSE, 2, 0);
        push(5, K_PULSE, 2, 1);
        push(7, K_PULSE, 2, 0);
        push(9, K_PULSE, 2, 1);
        push(10, K_OVF, 0, 0);
        chk("d_irq_pending", 32'({irq, irq_ovf}), 32'b10);
        do_start(2'b01, 8'd1, 8'd0, 8'd1, 1'b1);
        wait_rel(5);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("d_coincident", 32'({irq, irq_ovf}), 32'b10);
        wait_rel(10);
        do_stop();
        chk("d_after_stop", 32'({irq, irq_ovf, busy}), 32'b110);

        // E: reset in RUN with P=3, then cycle-0 timing again
        push(1, K_INIT, 0, 1);
        push(5, K_PULSE, 2, 1);
        do_start(2'b01, 8'd3, 8'd1, 8'd4, 1'b1);
        wait_rel(7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("e_rst_outs", 32'(outs), 32'd0);
        chk("e_rst_init_val", 32'(cnt_init_val), 32'd0);
        chk("e_rst_state", 32'(dbg_state), 32'd0);
        wait_rel(10);
        push_periodic_a();
        do_start(2'b01, 8'd1, 8'd2, 8'd5, 1'b1);
        wait_rel(12);
        do_stop();
        chk("e_final_busy", 32'(busy), 32'd0);
        wait_rel(16);

        while (exp_q.size() != 0) begin
            logic [31:0] left;
            left = exp_q.pop_front();
            n_checks++;
            n_err++;
            $display("FAIL missing_event: got none, expected rel=%0d kind=%0d data=%0d",
                     left[31:16], left[15:12], left[7:0]);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
